// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//
// Write-back end of the register-file interface.
//
// This block holds the MEM/WB pipeline register and chooses between the ALU
// result and load data. It drives the register-file write port. It also keeps
// a pending-write scoreboard with one small counter per register. The decode
// stage queries that scoreboard to detect RAW hazards.
//
// Optional feature (compile-time macro): WB_WRITE_THROUGH_EN
//   When this macro is defined, a register whose only pending writer is in WB
//   this cycle is not reported as pending. That writer is the committing,
//   non-frozen instruction. The register file is write-before-read, so decode
//   already sees the new value in that cycle. When the macro is undefined,
//   pending means "counter is non-zero".
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   freeze       hold the WB register; no retire, no scoreboard decrement
//   mem_valid    MEM stage presents an instruction
//   mem_wb_en    that instruction writes a register
//   mem_r_en     that instruction is a load (select mem_data)
//   mem_commit   0 = squashed: retire from the scoreboard but do not write
//   mem_dest     destination register of the MEM instruction
//   alu_result   EXE result
//   mem_data     load data
//   issue_valid  an instruction leaves decode this cycle
//   issue_wb_en  the issued instruction will write a register
//   issue_dest   destination of the issued instruction
//   src1, src2   decode source registers
//   two_src      src2 is live
//   wb_dest      register-file write address
//   wb_value     register-file write data
//   wb_we        register-file write enable
//   hazard       decode must stall
//   sb_error     sticky scoreboard overflow/underflow flag
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int REG_COUNT = 16,
  parameter int CNT_W     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              mem_valid,
  input  logic              mem_wb_en,
  input  logic              mem_r_en,
  input  logic              mem_commit,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic              issue_wb_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              two_src,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_value,
  output logic              wb_we,
  output logic              hazard,
  output logic              sb_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              wb_valid_q;
  logic              wb_en_q;
  logic              wb_commit_q;
  logic [ADDR_W-1:0] wb_dest_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [CNT_W-1:0]     cnt_q [REG_COUNT];
  logic [CNT_W-1:0]     cnt_d [REG_COUNT];
  logic [REG_COUNT-1:0] inc_hit;
  logic [REG_COUNT-1:0] dec_hit;
  logic [REG_COUNT-1:0] pend;
  logic                 err_set;
  logic                 retire;
  logic                 issue_fire;
  logic                 src1_pend;
  logic                 src2_pend;

  // MEM/WB register. While freeze is high, every field holds.
  // A MEM-stage bubble still loads, with valid cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q  <= 1'b0;
      wb_en_q     <= 1'b0;
      wb_commit_q <= 1'b0;
      wb_dest_q   <= '0;
      wb_data_q   <= '0;
    end else if (!freeze) begin
      wb_valid_q  <= mem_valid;
      wb_en_q     <= mem_wb_en;
      wb_commit_q <= mem_commit;
      wb_dest_q   <= mem_dest;
      wb_data_q   <= mem_r_en ? mem_data : alu_result;
    end
  end

  assign wb_dest  = wb_dest_q;
  assign wb_value = wb_data_q;
  assign wb_we    = wb_valid_q & wb_en_q & wb_commit_q & ~freeze;

  // A squashed instruction still retires, because its issue was counted.
  assign retire     = wb_valid_q & wb_en_q & ~freeze;
  assign issue_fire = issue_valid & issue_wb_en;

  // Work out which counter each event targets.
  // An out-of-range destination matches no counter.
  always_comb begin
    inc_hit = '0;
    dec_hit = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      inc_hit[r] = issue_fire && (issue_dest == ADDR_W'(r));
      dec_hit[r] = retire && (wb_dest_q == ADDR_W'(r));
    end
  end

  // Next counter values.
  // An increment and a decrement on the same edge cancel out.
  // Saturation at either end holds the counter and raises the error.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < REG_COUNT; r++) begin
      cnt_d[r] = cnt_q[r];
      if (inc_hit[r] && !dec_hit[r]) begin
        if (cnt_q[r] == CNT_MAX) begin
          err_set = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (cnt_q[r] == '0) begin
          err_set = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_COUNT; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_error <= 1'b0;
    end else if (err_set) begin
      sb_error <= 1'b1;
    end
  end

  // Per-register pending flags, taken from the registered counters only.
  // An issue in the current cycle is therefore not visible until the next edge.
  always_comb begin
    pend = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      pend[r] = (cnt_q[r] != '0);
`ifdef WB_WRITE_THROUGH_EN
      if ((cnt_q[r] == CNT_ONE) && wb_valid_q && wb_commit_q && wb_en_q &&
          !freeze && (wb_dest_q == ADDR_W'(r))) begin
        pend[r] = 1'b0;
      end
`endif
    end
  end

  // Register indices outside the tracked range are never pending.
  always_comb begin
    src1_pend = 1'b0;
    src2_pend = 1'b0;
    if (32'(src1) < REG_COUNT) begin
      src1_pend = pend[src1];
    end
    if (32'(src2) < REG_COUNT) begin
      src2_pend = pend[src2];
    end
  end

  assign hazard = src1_pend | (two_src & src2_pend);

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
//
// Testbench for wb_stage. The directed scenarios check fixed expected values.
// The randomized section checks the design against a behavioural model. That
// model keeps plain integer pending counts per register and a copy of the
// instruction sitting in WB.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze;
  logic        mem_valid;
  logic        mem_wb_en;
  logic        mem_r_en;
  logic        mem_commit;
  logic [3:0]  mem_dest;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic        issue_valid;
  logic        issue_wb_en;
  logic [3:0]  issue_dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        wb_we;
  logic        hazard;
  logic        sb_error;

  int errors = 0;
  int checks = 0;

  // Behavioural model state.
  int          m_cnt [16];
  bit          m_err;
  bit          m_valid;
  bit          m_en;
  bit          m_commit;
  logic [3:0]  m_dest;
  logic [31:0] m_data;

`ifdef WB_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .mem_valid   (mem_valid),
    .mem_wb_en   (mem_wb_en),
    .mem_r_en    (mem_r_en),
    .mem_commit  (mem_commit),
    .mem_dest    (mem_dest),
    .alu_result  (alu_result),
    .mem_data    (mem_data),
    .issue_valid (issue_valid),
    .issue_wb_en (issue_wb_en),
    .issue_dest  (issue_dest),
    .src1        (src1),
    .src2        (src2),
    .two_src     (two_src),
    .wb_dest     (wb_dest),
    .wb_value    (wb_value),
    .wb_we       (wb_we),
    .hazard      (hazard),
    .sb_error    (sb_error)
  );

  always #5 clk = ~clk;

  // Reset the model: no pending writers, empty WB slot, no error.
  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_err    = 1'b0;
    m_valid  = 1'b0;
    m_en     = 1'b0;
    m_commit = 1'b0;
    m_dest   = '0;
    m_data   = '0;
  endtask

  // A register is pending while it has writers in flight.
  // With write-through, the single committing writer in WB does not count.
  function automatic bit m_pend(logic [3:0] r);
    if (m_cnt[r] == 0) return 1'b0;
    if (WT && m_cnt[r] == 1 && m_valid && m_commit && m_en && m_dest == r && !freeze)
      return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one edge using the current inputs, then move to
  // 1 ns after the edge.
  task automatic tick();
    bit do_ret;
    bit do_iss;
    do_ret = m_valid && m_en && !freeze;
    do_iss = issue_valid && issue_wb_en;
    if (!(do_ret && do_iss && m_dest == issue_dest)) begin
      if (do_iss) begin
        if (m_cnt[issue_dest] == 3) m_err = 1'b1;
        else m_cnt[issue_dest] = m_cnt[issue_dest] + 1;
      end
      if (do_ret) begin
        if (m_cnt[m_dest] == 0) m_err = 1'b1;
        else m_cnt[m_dest] = m_cnt[m_dest] - 1;
      end
    end
    if (!freeze) begin
      m_valid  = mem_valid;
      m_en     = mem_wb_en;
      m_commit = mem_commit;
      m_dest   = mem_dest;
      m_data   = mem_r_en ? mem_data : alu_result;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    freeze      = 1'b0;
    mem_valid   = 1'b0;
    mem_wb_en   = 1'b0;
    mem_r_en    = 1'b0;
    mem_commit  = 1'b1;
    mem_dest    = '0;
    alu_result  = '0;
    mem_data    = '0;
    issue_valid = 1'b0;
    issue_wb_en = 1'b0;
    issue_dest  = '0;
  endtask

  task automatic do_reset();
    idle();
    src1    = '0;
    src2    = '0;
    two_src = 1'b0;
    rst     = 1'b0;
    model_clear();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(logic [3:0] d);
    issue_valid = 1'b1;
    issue_wb_en = 1'b1;
    issue_dest  = d;
  endtask

  task automatic present(logic [3:0] d, logic [31:0] alu, logic [31:0] ld, bit is_load, bit commit);
    mem_valid  = 1'b1;
    mem_wb_en  = 1'b1;
    mem_r_en   = is_load;
    mem_commit = commit;
    mem_dest   = d;
    alu_result = alu;
    mem_data   = ld;
  endtask

  task automatic test_reset();
    do_reset();
    issue(4'd1);
    tick();
    issue(4'd2);
    present(4'd1, 32'h11, 32'h0, 1'b0, 1'b1);
    tick();
    issue(4'd3);
    present(4'd2, 32'h22, 32'h0, 1'b0, 1'b1);
    tick();
    present(4'd3, 32'h33, 32'h0, 1'b0, 1'b1);
    src1 = 4'd3;
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", wb_we); end
    checks++;
    if (wb_dest !== 4'd0) begin errors++; $display("[TB] FAIL reset_dest: got %0d want 0", wb_dest); end
    checks++;
    if (wb_value !== 32'h0) begin errors++; $display("[TB] FAIL reset_value: got %h want 0", wb_value); end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL reset_hazard: got %b want 0", hazard); end
    checks++;
    if (sb_error !== 1'b0) begin errors++; $display("[TB] FAIL reset_sb_error: got %b want 0", sb_error); end
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    for (int r = 0; r < 16; r++) begin
      src1    = 4'(r);
      src2    = 4'(r);
      two_src = 1'b1;
      #1;
      checks++;
      if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL reset_sweep r%0d: got %b want 0", r, hazard); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_no_write: got %b want 0", wb_we); end
  endtask

  task automatic test_alu_write();
    do_reset();
    src1 = 4'd5;
    issue(4'd5);
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL alu_pre_issue_hazard: got %b want 0", hazard); end
    tick();
    idle();
    #2;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL alu_pending_hazard: got %b want 1", hazard); end
    tick();
    present(4'd5, 32'h1234, 32'hFFFF_0000, 1'b0, 1'b1);
    #2;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL alu_mem_hazard: got %b want 1", hazard); end
    tick();
    idle();
    #2;
    checks++;
    if (wb_we !== 1'b1) begin errors++; $display("[TB] FAIL alu_we: got %b want 1", wb_we); end
    checks++;
    if (wb_dest !== 4'd5) begin errors++; $display("[TB] FAIL alu_dest: got %0d want 5", wb_dest); end
    checks++;
    if (wb_value !== 32'h0000_1234) begin errors++; $display("[TB] FAIL alu_value: got %h want 00001234", wb_value); end
    checks++;
    if (hazard !== !WT) begin errors++; $display("[TB] FAIL alu_wb_hazard: got %b want %b", hazard, !WT); end
    tick();
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL alu_retired_hazard: got %b want 0", hazard); end
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL alu_after_we: got %b want 0", wb_we); end
  endtask

  task automatic test_load();
    do_reset();
    issue(4'd6);
    tick();
    idle();
    present(4'd6, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b1);
    tick();
    idle();
    #2;
    checks++;
    if (wb_value !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_value: got %h want deadbeef", wb_value); end
    checks++;
    if (wb_we !== 1'b1) begin errors++; $display("[TB] FAIL load_we: got %b want 1", wb_we); end
    checks++;
    if (wb_dest !== 4'd6) begin errors++; $display("[TB] FAIL load_dest: got %0d want 6", wb_dest); end
    tick();
    #2;
    checks++;
    if (sb_error !== 1'b0) begin errors++; $display("[TB] FAIL load_sb_error: got %b want 0", sb_error); end
  endtask

  task automatic test_squash();
    do_reset();
    issue(4'd3);
    tick();
    idle();
    present(4'd3, 32'h55, 32'h0, 1'b0, 1'b0);
    tick();
    idle();
    src1 = 4'd3;
    #2;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL squash_we: got %b want 0", wb_we); end
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL squash_wb_hazard: got %b want 1", hazard); end
    tick();
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL squash_retired_hazard: got %b want 0", hazard); end
    checks++;
    if (sb_error !== 1'b0) begin errors++; $display("[TB] FAIL squash_sb_error: got %b want 0", sb_error); end
  endtask

  task automatic test_freeze();
    do_reset();
    issue(4'd7);
    tick();
    idle();
    present(4'd7, 32'h77, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    freeze = 1'b1;
    present(4'd1, 32'h99, 32'h0, 1'b0, 1'b1);
    src1    = 4'd0;
    src2    = 4'd7;
    two_src = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++;
      if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL freeze_we c%0d: got %b want 0", c, wb_we); end
      checks++;
      if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL freeze_hazard c%0d: got %b want 1", c, hazard); end
      checks++;
      if (wb_dest !== 4'd7) begin errors++; $display("[TB] FAIL freeze_dest c%0d: got %0d want 7", c, wb_dest); end
      tick();
    end
    idle();
    #2;
    checks++;
    if (wb_we !== 1'b1) begin errors++; $display("[TB] FAIL freeze_release_we: got %b want 1", wb_we); end
    checks++;
    if (wb_value !== 32'h77) begin errors++; $display("[TB] FAIL freeze_release_value: got %h want 00000077", wb_value); end
    checks++;
    if (hazard !== !WT) begin errors++; $display("[TB] FAIL freeze_release_hazard: got %b want %b", hazard, !WT); end
    tick();
    #2;
    checks++;
    if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL freeze_single_write: got %b want 0", wb_we); end
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL freeze_after_hazard: got %b want 0", hazard); end
    tick();
    #2;
    checks++;
    if (sb_error !== 1'b0) begin errors++; $display("[TB] FAIL freeze_single_decrement: got %b want 0", sb_error); end
  endtask

  task automatic test_saturate();
    do_reset();
    src1 = 4'd2;
    for (int k = 0; k < 3; k++) begin
      issue(4'd2);
      tick();
    end
    idle();
    #2;
    checks++;
    if (sb_error !== 1'b0) begin errors++; $display("[TB] FAIL sat_three_error: got %b want 0", sb_error); end
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL sat_three_hazard: got %b want 1", hazard); end
    issue(4'd2);
    tick();
    idle();
    #2;
    checks++;
    if (sb_error !== 1'b1) begin errors++; $display("[TB] FAIL sat_overflow_error: got %b want 1", sb_error); end
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL sat_overflow_hazard: got %b want 1", hazard); end
    src1 = 4'd9;
    issue(4'd9);
    tick();
    idle();
    present(4'd9, 32'h9, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    issue(4'd9);
    #2;
    checks++;
    if (hazard !== !WT) begin errors++; $display("[TB] FAIL same_edge_wb_hazard: got %b want %b", hazard, !WT); end
    tick();
    idle();
    #2;
    checks++;
    if (hazard !== 1'b1) begin errors++; $display("[TB] FAIL same_edge_hazard: got %b want 1", hazard); end
    checks++;
    if (sb_error !== 1'b1) begin errors++; $display("[TB] FAIL sticky_error: got %b want 1", sb_error); end
    present(4'd9, 32'h9, 32'h0, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    #2;
    checks++;
    if (hazard !== 1'b0) begin errors++; $display("[TB] FAIL same_edge_count_one: got %b want 0", hazard); end
  endtask

  task automatic test_random();
    logic [3:0] inflight [$];
    bit         exp_haz;
    bit         exp_we;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      freeze      = ($urandom_range(0, 5) == 0);
      issue_valid = (inflight.size() < 4) && ($urandom_range(0, 1) == 1);
      issue_wb_en = ($urandom_range(0, 3) != 0);
      issue_dest  = 4'($urandom_range(0, 5));
      alu_result  = $urandom;
      mem_data    = $urandom;
      mem_r_en    = $urandom_range(0, 1);
      mem_commit  = ($urandom_range(0, 3) != 0);
      if (!freeze && inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        mem_valid = 1'b1;
        mem_wb_en = 1'b1;
        mem_dest  = inflight.pop_front();
      end else begin
        mem_valid = freeze ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_wb_en = $urandom_range(0, 1);
        mem_dest  = 4'($urandom_range(0, 15));
      end
      if (issue_valid && issue_wb_en) inflight.push_back(issue_dest);
      src1    = 4'($urandom_range(0, 7));
      src2    = 4'($urandom_range(0, 7));
      two_src = $urandom_range(0, 1);
      #2;
      exp_we  = m_valid && m_en && m_commit && !freeze;
      exp_haz = m_pend(src1) || (two_src && m_pend(src2));
      checks++;
      if (wb_we !== exp_we) begin errors++; $display("[TB] FAIL rand_we c%0d: got %b want %b", c, wb_we, exp_we); end
      checks++;
      if (wb_dest !== m_dest) begin errors++; $display("[TB] FAIL rand_dest c%0d: got %0d want %0d", c, wb_dest, m_dest); end
      checks++;
      if (wb_value !== m_data) begin errors++; $display("[TB] FAIL rand_value c%0d: got %h want %h", c, wb_value, m_data); end
      checks++;
      if (hazard !== exp_haz) begin errors++; $display("[TB] FAIL rand_hazard c%0d: got %b want %b", c, hazard, exp_haz); end
      checks++;
      if (sb_error !== m_err) begin errors++; $display("[TB] FAIL rand_sb_error c%0d: got %b want %b", c, sb_error, m_err); end
      tick();
    end
  endtask

  initial begin
    idle();
    src1    = '0;
    src2    = '0;
    two_src = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_alu_write();
    test_load();
    test_squash();
    test_freeze();
    test_saturate();
    test_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the register-file interface; the decode stage is the read end.
- Holds the MEM/WB pipeline register and selects ALU result or load data.
- Drives the register-file write port (dest, value, enable).
- Keeps a per-register pending-write scoreboard that decode queries for RAW hazards.

Parameters:
DATA_W, 32, datapath width
ADDR_W, 4, register index width
REG_COUNT, 16, architectural registers tracked
CNT_W, 2, scoreboard counter width (up to 3 in-flight writers per register)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
freeze  in  1  hold the WB register; no retire and no scoreboard decrement while high
mem_valid  in  1  MEM stage presents an instruction this cycle
mem_wb_en  in  1  instruction writes a register
mem_r_en  in  1  instruction is a load; select mem_data
mem_commit  in  1  0 = squashed instruction: retire from scoreboard, no write
mem_dest  in  ADDR_W  destination register
alu_result  in  DATA_W  EXE result
mem_data  in  DATA_W  load data
issue_valid  in  1  instruction leaves decode this cycle
issue_wb_en  in  1  issued instruction will write a register
issue_dest  in  ADDR_W  its destination
src1  in  ADDR_W  decode Rn
src2  in  ADDR_W  decode Rm/Rd
two_src  in  1  src2 is live
wb_dest  out  ADDR_W  register-file write address
wb_value  out  DATA_W  register-file write data
wb_we  out  1  register-file write enable
hazard  out  1  decode must stall
sb_error  out  1  sticky: counter overflow or underflow

Behaviour:
- Reset (rst low, async): clear WB register (valid=0, wb_en=0, commit=0, dest=0, data=0), all counters, and sb_error. Outputs then read wb_dest=0, wb_value=0, wb_we=0, hazard=0, sb_error=0.
- WB register update, when freeze=0:
  - load valid, wb_en, commit, dest.
  - data = mem_r_en ? mem_data : alu_result.
  - mem_valid=0 loads a bubble (valid=0).
- WB register update, when freeze=1: hold all fields.
- Latency: a MEM-stage instruction appears on wb_* one cycle after capture.
- wb_we = valid & wb_en & commit & ~freeze. The write is combinational from register outputs, so the register file samples it within the same cycle.
- Retire condition: valid & wb_en & ~freeze (commit not required).
  - Decrement counter[dest] at the end of the WB cycle, i.e. on the edge that replaces the WB register.
- Issue condition: issue_valid & issue_wb_en. Increment counter[issue_dest] on the rising edge.
- Same register, same edge, increment and decrement: counter unchanged.
- Increment at max (3): hold the counter, set sb_error.
- Decrement at 0: hold at 0, set sb_error.
- sb_error clears only on reset.
- hazard (combinational):
  - pend(r) = counter[r] != 0.
  - hazard = pend(src1) | (two_src & pend(src2)).
  - Issue on the current cycle does not affect hazard until the next edge.
- A register with index >= REG_COUNT is never pending.
- Reset mid-operation: in-flight scoreboard state is discarded, and no write fires after reset until a new capture.

Optional Feature:
WB_WRITE_THROUGH_EN
- Defined: pend(r) excludes the in-WB writer when counter[r]==1, valid, commit, wb_en, dest==r and freeze=0.
  - The register file is write-before-read, so decode sees the new value in the same cycle: one-cycle-shorter stall.
- Undefined: pend(r) is purely counter[r] != 0 (conservative).

Test Plan:
1. Reset with rst=0 mid-traffic -> next cycle wb_we=0, hazard=0, sb_error=0; all counters read 0 (hazard=0 for every src1 sweep).
2. Issue dest=5; two cycles later MEM presents dest=5, alu_result=0x1234, mem_r_en=0 -> wb_we=1, wb_dest=5, wb_value=0x00001234 one cycle later; hazard for src1=5 high from the issue edge until the retire edge, then 0 (one cycle earlier with WB_WRITE_THROUGH_EN).
3. Load: mem_r_en=1, mem_data=0xDEADBEEF, alu_result=0x40 -> wb_value=0xDEADBEEF.
4. Squash: mem_commit=0, dest=3, pending count 1 -> wb_we=0; counter[3] returns to 0, so hazard for src1=3 drops.
5. freeze=1 for 3 cycles with dest=7 in WB -> wb_we=0 and hazard(src2=7, two_src=1) stays 1 throughout; on release, one write and one decrement only.
6. Four issues to r2 without retire -> counter saturates at 3 and sb_error=1. Same-edge issue and retire on r9 with count 1 -> count stays 1 and hazard stays 1.
